dpram_burst_reader: RTL and testbench

Read-side initiator for the on-chip dual-port RAM read channel (ARADDR/ARVALID request, RDATA/RVALID/RREADY return). It accepts a burst command (start address, word count) and issues one RAM read per cycle, wrapping circularly over the address space. Returned words go into an internal credit-guarded FIFO and out as a valid/ready stream with a LAST marker. It is the read-channel consumer used by buffet drain/fill logic.

---
 rtl/dpram_burst_reader.sv | 137 +++++++++++++
 tb/tb_dpram_burst_reader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_burst_reader.sv
// Burst read initiator for the dual-port RAM read channel: issues one read per cycle
// under FIFO credit, buffers returned words and presents them as a stream with LAST.
module dpram_burst_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [LEN_WIDTH-1:0]  CMD_LEN,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic                  RVALID,
  output logic                  RREADY,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  DOUT_VALID,
  input  logic                  DOUT_READY,
  output logic                  DOUT_LAST,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_issue_q, rem_issue_d;
  logic [LEN_WIDTH-1:0]  rem_out_q, rem_out_d;
  logic                  inflight_q, inflight_d;
  logic                  done_q, done_d;
  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  logic credit_ok;
  logic issue;
  logic push;
  logic pop;
  logic fifo_nempty;

  // Credit counts the word already requested but not yet returned, so the FIFO can never overflow.
  assign credit_ok   = ({1'b0, fifo_cnt_q} + {{CNT_W{1'b0}}, inflight_q}) < (CNT_W + 1)'(FIFO_DEPTH);
  assign issue       = (state_q == S_ISSUE) && credit_ok;
  assign push        = RVALID;
  assign fifo_nempty = (fifo_cnt_q != '0);
  assign pop         = fifo_nempty && DOUT_READY;

  assign CMD_READY  = (state_q == S_IDLE);
  assign ARVALID    = issue;
  assign ARADDR     = addr_q;
  assign RREADY     = 1'b1;
  assign DOUT       = fifo_mem[rd_ptr_q];
  assign DOUT_VALID = fifo_nempty;
  assign DOUT_LAST  = fifo_nempty && (rem_out_q == LEN_WIDTH'(1));
  assign BUSY       = (state_q != S_IDLE);
  assign DONE       = done_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_issue_d = rem_issue_q;
    rem_out_d   = rem_out_q;
    inflight_d  = issue;
    done_d      = 1'b0;
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q;
    if (push && !pop) fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
    if (!push && pop) fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
    if (pop) rem_out_d = rem_out_q - LEN_WIDTH'(1);

    case (state_q)
      S_IDLE: begin
        if (CMD_VALID) begin
          addr_d      = CMD_ADDR;
          rem_issue_d = CMD_LEN;
          rem_out_d   = CMD_LEN;
          if (CMD_LEN == '0) done_d  = 1'b1;
          else               state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          addr_d      = addr_q + ADDR_WIDTH'(1);
          rem_issue_d = rem_issue_q - LEN_WIDTH'(1);
          if (rem_issue_q == LEN_WIDTH'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: ;
      default: state_d = S_IDLE;
    endcase

    // Burst completes when its last word leaves the FIFO, not when it is requested.
    if (pop && (rem_out_q == LEN_WIDTH'(1)) && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_issue_q <= '0;
      rem_out_q   <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_issue_q <= rem_issue_d;
      rem_out_q   <= rem_out_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_q] <= RDATA;
  end

endmodule

// File: tb/tb_dpram_burst_reader.sv
// Scoreboard bench for dpram_burst_reader with a one-cycle-latency RAM model.
module tb_dpram_burst_reader;

  localparam int AW = 10;
  localparam int DW = 64;
  localparam int LW = 11;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          CMD_VALID;
  logic          CMD_READY;
  logic [AW-1:0] CMD_ADDR;
  logic [LW-1:0] CMD_LEN;
  logic [AW-1:0] ARADDR;
  logic          ARVALID;
  logic [DW-1:0] RDATA;
  logic          RVALID;
  logic          RREADY;
  logic [DW-1:0] DOUT;
  logic          DOUT_VALID;
  logic          DOUT_READY;
  logic          DOUT_LAST;
  logic          BUSY;
  logic          DONE;

  dpram_burst_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN), .ARADDR(ARADDR), .ARVALID(ARVALID),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .DOUT(DOUT),
    .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY), .DOUT_LAST(DOUT_LAST),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
  } exp_t;

  logic [DW-1:0] mem [1024];
  exp_t          sb [$];
  logic [AW-1:0] aq [$];
  exp_t          e_cur;
  logic [AW-1:0] a_cur;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ar_cnt, dv_cnt, done_cnt, first_ar, first_dv, done_cyc, issued, popped, t_acc;

  // RAM model: registered read data, one cycle after the request.
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) RVALID <= 1'b0;
    else begin
      RVALID <= ARVALID;
      if (ARVALID) RDATA <= mem[ARADDR];
    end
  end

  always @(posedge CLK) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a request or a beat.
  always @(negedge CLK) begin
    if (RESET) begin
      if (ARVALID) begin
        if (aq.size() == 0) chk("araddr_unexpected", 64'(ARADDR), 64'hFFFF);
        else begin
          a_cur = aq.pop_front();
          chk("araddr", 64'(ARADDR), 64'(a_cur));
        end
        ar_cnt++;
        issued++;
        if (first_ar < 0) first_ar = cyc;
      end
      if (DOUT_VALID) begin
        dv_cnt++;
        if (first_dv < 0) first_dv = cyc;
      end
      if (DOUT_VALID && DOUT_READY) begin
        popped++;
        if (sb.size() == 0) chk("beat_unexpected", DOUT, 64'hDEAD);
        else begin
          e_cur = sb.pop_front();
          chk("dout", DOUT, e_cur.d);
          chk("dout_last", 64'(DOUT_LAST), 64'(e_cur.last));
        end
      end
      if (ARVALID) chk("credit_le4", 64'((issued - popped) <= 4), 64'd1);
      if (DONE) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_trk();
    ar_cnt = 0; dv_cnt = 0; first_ar = -1; first_dv = -1; done_cyc = -1;
  endtask

  task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
    logic [AW-1:0] ad;
    exp_t e;
    int n;
    for (int k = 0; k < int'(l); k++) begin
      ad = a + AW'(k);
      aq.push_back(ad);
      e.d = mem[ad];
      e.last = (k == int'(l) - 1);
      sb.push_back(e);
    end
    @(posedge CLK); #1;
    CMD_VALID = 1'b1; CMD_ADDR = a; CMD_LEN = l;
    n = 0;
    @(negedge CLK);
    while (!CMD_READY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!CMD_READY) chk("cmd_accept_timeout", 64'd0, 64'd1);
    t_acc = cyc;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      @(posedge CLK); #1;
      if (rnd) DOUT_READY = 1'($urandom_range(0, 1));
      n++;
    end
    DOUT_READY = 1'b1;
    chk("done_seen", 64'(done_cnt != start), 64'd1);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cmd_ready"}, 64'(CMD_READY), 64'd1);
    chk({tag, "_arvalid"}, 64'(ARVALID), 64'd0);
    chk({tag, "_araddr"}, 64'(ARADDR), 64'd0);
    chk({tag, "_rready"}, 64'(RREADY), 64'd1);
    chk({tag, "_dout_valid"}, 64'(DOUT_VALID), 64'd0);
    chk({tag, "_dout_last"}, 64'(DOUT_LAST), 64'd0);
    chk({tag, "_busy"}, 64'(BUSY), 64'd0);
    chk({tag, "_done"}, 64'(DONE), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int d0;
    for (int i = 0; i < 1024; i++)
      mem[i] = {32'hBEEF_0000 | 32'(i), 32'h1234_0000 + 32'(i * 7)};
    for (int k = 0; k < 4; k++) mem[16 + k] = 64'hA0 + 64'(k);

    RESET = 1'b0; CMD_VALID = 1'b0; CMD_ADDR = '0; CMD_LEN = '0; DOUT_READY = 1'b1;
    done_cnt = 0; issued = 0; popped = 0; t_acc = 0;
    clear_trk();
    #3;
    chk_reset_outs("rst");
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;

    // Four words from 0x10, stream always ready: latency and DONE timing.
    clear_trk();
    send_cmd(10'h010, 11'd4);
    wait_done(100, 1'b0);
    chk("t1_first_ar", 64'(first_ar), 64'(t_acc + 1));
    chk("t1_first_dv", 64'(first_dv), 64'(t_acc + 3));
    chk("t1_done_cyc", 64'(done_cyc), 64'(t_acc + 7));
    chk("t1_ar_cnt", 64'(ar_cnt), 64'd4);

    // Ten words with the stream stalled: only four requests fit the credit.
    clear_trk();
    DOUT_READY = 1'b0;
    send_cmd(10'h010, 11'd10);
    repeat (12) @(posedge CLK);
    #1;
    chk("t2_ar_stall", 64'(ar_cnt), 64'd4);
    chk("t2_arvalid_low", 64'(ARVALID), 64'd0);
    chk("t2_dout_valid", 64'(DOUT_VALID), 64'd1);
    chk("t2_busy", 64'(BUSY), 64'd1);
    DOUT_READY = 1'b1;
    wait_done(200, 1'b0);
    chk("t2_ar_total", 64'(ar_cnt), 64'd10);

    // Address wrap across the top of the RAM.
    clear_trk();
    send_cmd(10'h3FE, 11'd4);
    wait_done(100, 1'b0);
    chk("t3_ar_cnt", 64'(ar_cnt), 64'd4);

    // Zero-length command.
    clear_trk();
    d0 = done_cnt;
    send_cmd(10'h055, 11'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      chk("t4_cmd_ready", 64'(CMD_READY), 64'd1);
    end
    chk("t4_done_cnt", 64'(done_cnt), 64'(d0 + 1));
    chk("t4_done_cyc", 64'(done_cyc), 64'(t_acc + 1));
    chk("t4_no_ar", 64'(ar_cnt), 64'd0);
    chk("t4_no_dv", 64'(dv_cnt), 64'd0);

    // 64 words with random back-pressure.
    clear_trk();
    send_cmd(10'h100, 11'd64);
    wait_done(3000, 1'b1);
    chk("t5_ar_cnt", 64'(ar_cnt), 64'd64);

    // Reset mid-burst after three beats, then a fresh two-word burst.
    clear_trk();
    popped = 0; issued = 0;
    send_cmd(10'h020, 11'd8);
    n = 0;
    while (popped < 3 && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("t6_three_beats", 64'(popped >= 3), 64'd1);
    #1 RESET = 1'b0;
    #1 chk_reset_outs("midrst");
    aq.delete(); sb.delete();
    issued = 0; popped = 0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    d0 = done_cnt;
    repeat (5) @(posedge CLK);
    #1 chk("t6_no_done_after_abort", 64'(done_cnt), 64'(d0));
    clear_trk();
    send_cmd(10'h030, 11'd2);
    wait_done(100, 1'b0);
    chk("t6_ar_cnt", 64'(ar_cnt), 64'd2);

    repeat (3) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
